// File: rtl/instruction_fetch.sv
// instruction_fetch: IF stage, one outstanding imem read, stall/redirect.
// Ports: clock/reset_n, stall, redirect(+pc), imem req/rsp, IF/ID outputs.
module instruction_fetch #(
  parameter int                  PC_WIDTH    = 8,
  parameter int                  INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   stall,
  input  logic                   redirect,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_rvalid,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic                   valid_out,
  output logic [INSTR_WIDTH-1:0] instruction_out,
  output logic [PC_WIDTH-1:0]    pc_out
);

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    PRESENT,
    DISCARD
  } state_t;

  state_t                 state;
  state_t                 state_d;
  logic [PC_WIDTH-1:0]    pc;
  logic [PC_WIDTH-1:0]    pc_d;
  logic [PC_WIDTH-1:0]    pc_inc;
  logic [PC_WIDTH-1:0]    target;
  logic                   valid_d;
  logic [INSTR_WIDTH-1:0] instr_d;
  logic [PC_WIDTH-1:0]    pc_out_d;

  // Word-aligned redirect target; wraps modulo 2^PC_WIDTH.
  assign target = {redirect_pc[PC_WIDTH-1:2], 2'b00};
  assign pc_inc = pc + PC_WIDTH'(4);

  assign imem_req  = (state == REQ);
  assign imem_addr = pc;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= REQ;
      pc              <= RESET_PC;
      valid_out       <= 1'b0;
      instruction_out <= '0;
      pc_out          <= '0;
    end else begin
      state           <= state_d;
      pc              <= pc_d;
      valid_out       <= valid_d;
      instruction_out <= instr_d;
      pc_out          <= pc_out_d;
    end
  end

  always_comb begin
    state_d  = state;
    pc_d     = pc;
    valid_d  = valid_out;
    instr_d  = instruction_out;
    pc_out_d = pc_out;
    if (redirect) begin
      // Redirect wins over stall and rvalid. A request already
      // issued to the old path must have its response swallowed.
      pc_d    = target;
      valid_d = 1'b0;
      unique case (state)
        REQ:     state_d = DISCARD;
        WAIT:    state_d = imem_rvalid ? REQ : DISCARD;
        PRESENT: state_d = REQ;
        DISCARD: state_d = imem_rvalid ? REQ : DISCARD;
        default: state_d = REQ;
      endcase
    end else begin
      unique case (state)
        REQ: begin
          state_d = WAIT;
        end
        WAIT: begin
          if (imem_rvalid) begin
            instr_d  = imem_rdata;
            pc_out_d = pc;
            valid_d  = 1'b1;
            pc_d     = pc_inc;
            state_d  = PRESENT;
          end
        end
        PRESENT: begin
          if (!stall) begin
            valid_d = 1'b0;
            state_d = REQ;
          end
        end
        DISCARD: begin
          if (imem_rvalid) begin
            state_d = REQ;
          end
        end
        default: begin
          state_d = REQ;
        end
      endcase
    end
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the MIPS pipeline. Holds the byte-addressed program counter and issues one instruction-memory read at a time over a request/response handshake. It presents each returned instruction with its fetch PC to the IF/ID pipeline register, which adds 4 to the PC itself. Supports a stall from the hazard unit and a PC redirect from branch/jump resolution, including squashing of in-flight fetches.

## Interface
- PC_WIDTH, 8: width of PC and instruction-memory address (byte address)
- INSTR_WIDTH, 32: instruction width
- RESET_PC, 8'h00: PC after reset; bits [1:0] must be 0
- clock  in  1  single clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- stall  in  1  downstream cannot accept; holds the presented instruction
- redirect  in  1  load redirect_pc as next fetch PC, squash current fetch
- redirect_pc  in  PC_WIDTH  redirect target; bits [1:0] ignored (treated as 0)
- imem_req  out  1  read request, one-cycle pulse
- imem_addr  out  PC_WIDTH  read address, equal to the current PC
- imem_rvalid  in  1  read data valid, exactly one pulse per request, at least 1 cycle after imem_req
- imem_rdata  in  INSTR_WIDTH  read data, sampled when imem_rvalid=1
- valid_out  out  1  instruction_out/pc_out hold a valid fetched instruction
- instruction_out  out  INSTR_WIDTH  fetched instruction
- pc_out  out  PC_WIDTH  address the instruction was fetched from (not incremented)

## Operation
- States: REQ, WAIT, PRESENT, DISCARD. Reset state is REQ.
- Reset values: pc=RESET_PC, valid_out=0, instruction_out=0 (NOP), pc_out=0. imem_req and imem_addr follow from state=REQ and pc.
- imem_req=1 only in REQ. imem_addr=pc in all states.
- REQ: always go to WAIT after one cycle.
- WAIT: on imem_rvalid, register instruction_out<=imem_rdata, pc_out<=pc, valid_out<=1, pc<=pc+4, then go to PRESENT. Otherwise stay in WAIT.
- PRESENT: valid_out=1. If stall=0, the instruction is consumed this cycle: valid_out<=0, go to REQ. If stall=1, hold all outputs and stay.
- DISCARD: a squashed request is outstanding. On imem_rvalid, drop the data and go to REQ.
- PC arithmetic is modulo 2^PC_WIDTH, so 8'hFC+4 wraps to 8'h00. No carry out.
- Redirect has priority over every other event in every state. It sets pc<=redirect_pc & ~3 and valid_out<=0, and it ignores stall. Next state:
  - REQ: DISCARD (the old-address request was issued this cycle).
  - WAIT without rvalid: DISCARD.
  - WAIT with rvalid in the same cycle: the data is dropped and pc is not incremented; go to REQ.
  - PRESENT: REQ. The presented instruction is withdrawn.
  - DISCARD without rvalid: stay in DISCARD. With rvalid: REQ.
- Stall has no effect in REQ, WAIT or DISCARD.
- imem_rvalid in REQ or PRESENT is a protocol violation and is ignored.
- Reset mid-operation: all state returns to reset values immediately. Instruction memory is reset by the same reset_n, so no stale response survives.

## Timing
- Fetch latency from imem_req to valid_out = memory latency + 1 cycle.
- Memory latency L means rvalid arrives L cycles after req. Issue rate is one instruction per L+2 cycles with no stall.
- Outputs are registered, except imem_req and imem_addr, which are decoded from registered state and pc.
- Redirect takes effect on the next edge. The first request to the target is issued in the cycle after redirect, or in the cycle after the discarded rvalid.

## Test plan
- Reset, then L=1 memory returning 0x20000000+addr, no stall: requests at addr 0,4,8. valid_out pulses 3 cycles apart with pc_out 0,4,8 and the matching instruction_out.
- Stall held 3 cycles while in PRESENT at pc_out=4: outputs frozen and valid_out=1 throughout, no imem_req. After release, the next request goes to addr 8.
- Redirect to 8'h43 while in WAIT (L=3): the response arrives and is dropped, valid_out stays 0, and the next request goes to 8'h40. pc_out later = 8'h40.
- Redirect in the same cycle as rvalid: data dropped, next imem_addr = target. Redirect with stall=1 in PRESENT: valid_out drops, and the request to the target is issued next cycle.
- Start with RESET_PC=8'hF8: fetches go 8'hF8, 8'hFC, 8'h00 (wrap).
- Assert reset_n=0 mid-WAIT: outputs return to 0 asynchronously. After release, the request goes to RESET_PC.
